// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: the operation
// encoding and the single-bit gate evaluator used for every result bit.
package logic_gate_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_BUF  = 3'b111
  } logic_op_t;

  // Evaluated one bit at a time so the unit works for any operand width
  // without a fixed maximum or unused upper bits.
  function automatic logic logic_op_eval(input logic a, input logic b,
                                         input logic_op_t op);
    logic r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_BUF:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One valid/ready register slice. The slice loads whenever it is empty or
// its downstream neighbour is taking the current beat, so bubbles collapse.
module logic_gate_stage
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_ready;

  assign w_ready = !r_valid || i_ready;
  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Slice register: reset empties it, otherwise load from upstream when ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_ready) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// WIDTH-bit bitwise logic unit: combinational op decode ahead of a STAGES-deep
// valid/ready register chain, plus a counter of completed output transfers.
// in_ready is combinational on out_ready through the ready chain.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] xfer_count
);

  logic_op_t          w_op;
  logic [WIDTH-1:0]   w_result;
  logic [STAGES:0]    w_valid;
  logic [STAGES:0]    w_ready;
  logic [WIDTH-1:0]   w_data [0:STAGES];
  logic [COUNT_W-1:0] r_xfer;

  assign w_op = logic_op_t'(in_op);

  // Result is formed before stage 0; the op code is not carried down the pipe.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign w_result[g] = logic_op_eval(in_a[g], in_b[g], w_op);
  end

  // Index 0 is the input side, index STAGES the output side of the chain.
  assign w_valid[0]      = in_valid;
  assign w_data[0]       = w_result;
  assign w_ready[STAGES] = out_ready;
  assign in_ready        = w_ready[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic_gate_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_valid[s]),
      .i_data (w_data[s]),
      .o_ready(w_ready[s]),
      .o_valid(w_valid[s+1]),
      .o_data (w_data[s+1]),
      .i_ready(w_ready[s+1])
    );
  end

  assign out_valid  = w_valid[STAGES];
  assign out_data   = w_data[STAGES];
  assign xfer_count = r_xfer;

  // Count output handshakes, wrapping naturally; reset wins over a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer <= '0;
    end else if (out_valid && out_ready) begin
      r_xfer <= r_xfer + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: the driver publishes the hand-computed
// expected result of each beat, the monitor queues it on the input handshake
// and compares it on the output handshake.
module tb_logic_gate_pipe;

  localparam int WIDTH   = 8;
  localparam int STAGES  = 2;
  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] xfer_count;

  logic_gate_pipe #(
    .WIDTH(WIDTH), .STAGES(STAGES), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  logic [WIDTH-1:0] drv_exp;
  logic [WIDTH-1:0] exp_q[$];
  int pop_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: reset discards in-flight expectations; otherwise pop on output
  // handshake, push on input handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected no output", out_data);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  // Present one beat and hold it until accepted; returns 1 ns after the
  // accepting edge with in_valid low.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [7:0] e);
    in_a = a; in_b = b; in_op = op; drv_exp = e; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(posedge clk); #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  logic [7:0] ops_exp [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
  int p0;
  int bad;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b0; drv_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // NOT with latency check
    out_ready = 1'b1;
    send(8'hA5, 8'h00, 3'b000, 8'h5A);
    @(negedge clk);
    chk("lat_early_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("not_data", out_data, 8'h5A);
    @(posedge clk); #1;
    @(negedge clk);
    chk("xfer_after_not", xfer_count, 1);
    @(posedge clk); #1;

    // All ops back to back
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i), ops_exp[i]);
    drain();
    chk("ops_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("ops_consecutive", pop_cyc[7] - pop_cyc[0], 7);

    // Backpressure from the start
    p0 = pops;
    out_ready = 1'b0;
    send(8'h01, 8'h00, 3'b111, 8'h01);
    send(8'h02, 8'h00, 3'b111, 8'h02);
    in_a = 8'h03; in_op = 3'b111; drv_exp = 8'h03; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 8'h01);
    repeat (2) @(negedge clk);
    chk("bp_hold_data", out_data, 8'h01);
    chk("bp_hold_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h03, 8'h00, 3'b111, 8'h03);
    send(8'h04, 8'h00, 3'b111, 8'h04);
    send(8'h05, 8'h00, 3'b111, 8'h05);
    drain();
    chk("bp_count", pops - p0, 5);

    // Reset mid-operation with handshakes on both sides
    out_ready = 1'b0;
    send(8'h11, 8'h00, 3'b111, 8'h11);
    send(8'h22, 8'h00, 3'b111, 8'h22);
    in_a = 8'h33; in_op = 3'b111; drv_exp = 8'h33; in_valid = 1'b1;
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    p0 = pops;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_xfer", xfer_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_stale", pops - p0, 0);
    @(posedge clk); #1;

    // Counter wrap
    for (int i = 0; i < 16; i++) send(8'(i + 8'h40), 8'h00, 3'b111, 8'(i + 8'h40));
    drain();
    chk("wrap_16", xfer_count, 0);
    send(8'h77, 8'h00, 3'b111, 8'h77);
    drain();
    chk("wrap_17", xfer_count, 1);

    // Full-pipe streaming
    out_ready = 1'b0;
    send(8'hA1, 8'h00, 3'b111, 8'hA1);
    send(8'hA2, 8'h00, 3'b111, 8'hA2);
    pop_cyc.delete();
    bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = 8'(8'hB0 + i); in_op = 3'b111; drv_exp = 8'(8'hB0 + i); in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_in_ready_drops", bad, 0);
    drain();
    chk("stream_count", pop_cyc.size(), 12);
    if (pop_cyc.size() == 12) chk("stream_consecutive", pop_cyc[11] - pop_cyc[0], 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
